uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Sequencing controller for the UART receive path. It detects a start condition on the serial line and tracks oversampling ticks and bit position. It issues one-cycle enables to the sampler, deserializer, start, parity and stop checkers. It qualifies the frame with their error flags and raises `data_valid` for clean frames. The block sits between the raw `rx_in` pin and the receive datapath, and is the only block that drives the checkers' enable inputs.

## Interface
- `PRESCALE`, 8: clk2 cycles per serial bit; even, ≥4, ≤32.
- `DATA_WIDTH`, 8: data bits per frame; 5–9.
- `clk2` in 1: oversampling clock; all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rx_in` in 1: serial line, idle high.
- `par_en` in 1: parity bit present; latched at start detection.
- `strt_glitch` in 1: start checker flag; registered, valid the cycle after `strt_chk_en`.
- `par_err` in 1: parity checker flag; valid the cycle after `par_chk_en`.
- `stop_err` in 1: stop checker flag; valid the cycle after `stop_chk_en`.
- `dat_samp_en` out 1: sampler enable; high in every state except IDLE.
- `edge_cnt` out 5: tick index within the current bit, 0..PRESCALE-1.
- `strt_chk_en` out 1: one-cycle pulse at the end of the start bit.
- `deser_en` out 1: one-cycle pulse at the end of each data bit.
- `par_chk_en` out 1: one-cycle pulse at the end of the parity bit.
- `stop_chk_en` out 1: one-cycle pulse at the end of the stop bit.
- `data_valid` out 1: one-cycle pulse for an error-free frame.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, CHECK.
- Counters:
  - `edge_cnt` increments every cycle outside IDLE and CHECK, and wraps PRESCALE-1 → 0.
  - `bit_cnt` (4 bit) increments on each `edge_cnt` wrap.
  - Both counters are cleared on entry to START and in IDLE.
- IDLE → START: `rx_in`==0 while in IDLE. Latch `par_en` into `par_en_q` in the same cycle.
- START:
  - At `edge_cnt`==PRESCALE-1, pulse `strt_chk_en` and go to DATA.
  - In the first DATA cycle (`edge_cnt`==0, `bit_cnt`==1), if `strt_glitch`==1: go to IDLE, clear counters, no `data_valid`.
- DATA:
  - At `edge_cnt`==PRESCALE-1, pulse `deser_en`.
  - When this is also the last data bit (`bit_cnt`==DATA_WIDTH), go to PARITY if `par_en_q`, else STOP.
- PARITY: at `edge_cnt`==PRESCALE-1, pulse `par_chk_en`, go to STOP.
- STOP: at `edge_cnt`==PRESCALE-1, pulse `stop_chk_en`, go to CHECK.
- CHECK (exactly one cycle):
  - `data_valid` = !`stop_err` && !(`par_en_q` && `par_err`).
  - Next state is START if `rx_in`==0 (back-to-back frame; re-latch `par_en`), else IDLE.
- At most one of the four check/deser enables is high in any cycle.
- `par_en` changes after latching have no effect until the next start detection.
- `par_err` is ignored when `par_en_q`==0.

## Timing
- Reset (async, `rst`=0):
  - State IDLE, counters 0.
  - All outputs 0, including `edge_cnt`=0, `busy`=0, `dat_samp_en`=0.
- Reset release mid-frame: the block restarts in IDLE and waits for the next falling `rx_in`.
- Start detection latency: `busy`/`dat_samp_en` rise 1 cycle after the first sampled `rx_in`==0.
- Enable pulses occur at `edge_cnt`==PRESCALE-1 of bit N, i.e. N·PRESCALE + PRESCALE-1 cycles after START entry.
- `data_valid` timing: the CHECK cycle is (2+DATA_WIDTH+`par_en_q`)·PRESCALE cycles after START entry, and `data_valid` is registered out of it.
- Frame length, START entry → return to IDLE/START: (2+DATA_WIDTH+`par_en_q`)·PRESCALE + 1 cycles.
- Glitch abort: IDLE is reached PRESCALE+1 cycles after START entry.
- `rx_in` is only examined in IDLE and CHECK. It is not examined mid-frame; sampling is the sampler's job.

## Test plan
- Clean frame, PRESCALE=8, DATA_WIDTH=8, par_en=0, data 0xA5:
  - exactly 8 `deser_en` pulses, spaced 8 cycles;
  - `stop_chk_en` at cycle 79 after START entry;
  - `data_valid`=1 for 1 cycle at cycle 81;
  - `busy` then low.
- Parity frame, par_en=1, `par_err` held 0:
  - `par_chk_en` at cycle 79, `stop_chk_en` at 87;
  - `data_valid` pulse.
  - Repeat with `par_err`=1 → `data_valid` stays 0, FSM returns to IDLE.
- Stop error: `stop_err`=1 after `stop_chk_en` → `data_valid`=0, IDLE.
- Start glitch: `strt_glitch`=1 after `strt_chk_en` → IDLE at cycle 9, no `deser_en` ever pulses.
- Back-to-back:
  - `rx_in`=0 in the CHECK cycle → START entered directly, second frame decoded;
  - `par_en` toggled mid-frame does not alter the first frame's bit count.
- Async reset asserted during DATA (`bit_cnt`=4) → all outputs 0 immediately. After release with `rx_in`=1, the block stays IDLE.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// Receive-path sequencer: detects the start bit, walks oversampling ticks and bit
// positions, strobes the sampler/deserializer/checkers and qualifies each frame.
module uart_rx_ctrl #(
  parameter int unsigned PRESCALE   = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic       clk2,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       par_en,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stop_err,
  output logic       dat_samp_en,
  output logic [4:0] edge_cnt,
  output logic       strt_chk_en,
  output logic       deser_en,
  output logic       par_chk_en,
  output logic       stop_chk_en,
  output logic       data_valid,
  output logic       busy
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;
  localparam logic [2:0] StCheck  = 3'd5;

  localparam logic [4:0] EdgeLast = 5'(PRESCALE - 1);
  localparam logic [3:0] BitLast  = 4'(DATA_WIDTH);

  logic [2:0] state_q, state_d;
  logic [4:0] edge_q, edge_d;
  logic [3:0] bit_q, bit_d;
  logic       par_en_q, par_en_d;
  logic       data_valid_q, data_valid_d;

  logic last_tick;
  logic start_det;
  logic glitch_abort;
  logic counting;

  assign last_tick = (edge_q == EdgeLast);
  // The line is only looked at while waiting for a frame or in the one-cycle check slot.
  assign start_det = ((state_q == StIdle) || (state_q == StCheck)) && !rx_in;
  // Start checker's verdict arrives in the first data-bit cycle.
  assign glitch_abort = (state_q == StData) && (edge_q == 5'd0) && (bit_q == 4'd1)
                        && strt_glitch;
  assign counting = (state_q != StIdle) && (state_q != StCheck);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start_det) state_d = StStart;
      end
      StStart: begin
        if (last_tick) state_d = StData;
      end
      StData: begin
        if (glitch_abort) begin
          state_d = StIdle;
        end else if (last_tick && (bit_q == BitLast)) begin
          state_d = par_en_q ? StParity : StStop;
        end
      end
      StParity: begin
        if (last_tick) state_d = StStop;
      end
      StStop: begin
        if (last_tick) state_d = StCheck;
      end
      StCheck: begin
        state_d = start_det ? StStart : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    edge_d = edge_q;
    bit_d  = bit_q;
    if ((state_d == StIdle) || start_det) begin
      edge_d = 5'd0;
      bit_d  = 4'd0;
    end else if (counting) begin
      if (last_tick) begin
        edge_d = 5'd0;
        bit_d  = bit_q + 4'd1;
      end else begin
        edge_d = edge_q + 5'd1;
      end
    end
  end

  assign par_en_d     = start_det ? par_en : par_en_q;
  assign data_valid_d = (state_q == StCheck) && !stop_err && !(par_en_q && par_err);

  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      edge_q       <= 5'd0;
      bit_q        <= 4'd0;
      par_en_q     <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_q       <= edge_d;
      bit_q        <= bit_d;
      par_en_q     <= par_en_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign dat_samp_en = (state_q != StIdle);
  assign edge_cnt    = edge_q;
  assign strt_chk_en = (state_q == StStart) && last_tick;
  assign deser_en    = (state_q == StData) && last_tick;
  assign par_chk_en  = (state_q == StParity) && last_tick;
  assign stop_chk_en = (state_q == StStop) && last_tick;
  assign data_valid  = data_valid_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at PRESCALE=8, DATA_WIDTH=8; cycle numbers are
// counted from the first cycle spent in START.
module tb_uart_rx_ctrl;

  logic       clk2 = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic       par_en = 1'b0;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stop_err = 1'b0;
  logic       dat_samp_en;
  logic [4:0] edge_cnt;
  logic       strt_chk_en;
  logic       deser_en;
  logic       par_chk_en;
  logic       stop_chk_en;
  logic       data_valid;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  uart_rx_ctrl #(
    .PRESCALE  (8),
    .DATA_WIDTH(8)
  ) dut (
    .clk2       (clk2),
    .rst        (rst),
    .rx_in      (rx_in),
    .par_en     (par_en),
    .strt_glitch(strt_glitch),
    .par_err    (par_err),
    .stop_err   (stop_err),
    .dat_samp_en(dat_samp_en),
    .edge_cnt   (edge_cnt),
    .strt_chk_en(strt_chk_en),
    .deser_en   (deser_en),
    .par_chk_en (par_chk_en),
    .stop_chk_en(stop_chk_en),
    .data_valid (data_valid),
    .busy       (busy)
  );

  always #5 clk2 = ~clk2;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  function automatic logic [11:0] all_outs();
    return {dat_samp_en, edge_cnt, strt_chk_en, deser_en, par_chk_en, stop_chk_en,
            data_valid, busy};
  endfunction

  // Drive a falling edge from IDLE; returns at the negedge of START cycle 0.
  task automatic start_frame(input logic par);
    @(negedge clk2);
    rx_in  = 1'b0;
    par_en = par;
    @(negedge clk2);
  endtask

  // Entered at the negedge of cycle 0; returns at the negedge of the return-to-idle cycle.
  task automatic frame_body(input string nm, input logic par, input logic perr,
                            input logic serr, input logic glitch, input logic b2b,
                            input logic toggle, input logic [7:0] data);
    int check_cyc, end_cyc, ov;
    int n_deser, deser_first, deser_last, strt_cyc, par_cyc, stop_cyc;
    int dv_cyc, dv_n, idle_cyc, n_en;
    logic [11:0] bits;
    bool_exp_t: begin end
    bits        = par ? {2'b11, ^data, data, 1'b0} : {3'b111, data, 1'b0};
    check_cyc   = (10 + int'(par)) * 8;
    end_cyc     = glitch ? 9 : check_cyc + 1;
    n_deser     = 0;
    deser_first = -1;
    deser_last  = -1;
    strt_cyc    = -1;
    par_cyc     = -1;
    stop_cyc    = -1;
    dv_cyc      = -1;
    dv_n        = 0;
    idle_cyc    = -1;
    ov          = 0;
    strt_glitch = 1'b0;
    par_err     = perr;
    stop_err    = serr;
    for (int k = 0; k <= end_cyc; k++) begin
      if (k > 0) @(negedge clk2);
      if (k == 0) begin
        check({nm, ".busy0"}, busy, 1);
        check({nm, ".edge0"}, edge_cnt, 0);
      end
      if (strt_chk_en && strt_cyc < 0) strt_cyc = k;
      if (par_chk_en && par_cyc < 0) par_cyc = k;
      if (stop_chk_en && stop_cyc < 0) stop_cyc = k;
      if (deser_en) begin
        if (n_deser > 0) check({nm, ".deser_gap"}, k - deser_last, 8);
        else deser_first = k;
        deser_last = k;
        n_deser++;
      end
      if (k > 0 && data_valid) begin
        dv_n++;
        if (dv_cyc < 0) dv_cyc = k;
      end
      if (!busy && idle_cyc < 0) idle_cyc = k;
      n_en = int'(strt_chk_en) + int'(deser_en) + int'(par_chk_en) + int'(stop_chk_en);
      if (n_en > 1) ov++;
      if (strt_chk_en) strt_glitch = glitch;
      if (glitch && k > 0) rx_in = 1'b1;
      else if (k == check_cyc) rx_in = !b2b;
      else if (k > 0 && k < check_cyc) rx_in = bits[k / 8];
      if (k == 1 && toggle) par_en = !par_en;
    end
    if (!b2b) rx_in = 1'b1;
    strt_glitch = 1'b0;
    check({nm, ".strt_cyc"}, strt_cyc, 7);
    check({nm, ".n_deser"}, n_deser, glitch ? 0 : 8);
    check({nm, ".deser_first"}, deser_first, glitch ? -1 : 15);
    check({nm, ".deser_last"}, deser_last, glitch ? -1 : 71);
    check({nm, ".par_cyc"}, par_cyc, (!glitch && par) ? 79 : -1);
    check({nm, ".stop_cyc"}, stop_cyc, glitch ? -1 : (par ? 87 : 79));
    check({nm, ".dv_cyc"}, dv_cyc,
          (!glitch && !serr && !(par && perr)) ? check_cyc + 1 : -1);
    check({nm, ".dv_n"}, dv_n, (!glitch && !serr && !(par && perr)) ? 1 : 0);
    check({nm, ".idle_cyc"}, idle_cyc, b2b ? -1 : end_cyc);
    check({nm, ".overlap"}, ov, 0);
  endtask

  initial begin
    int n_busy;
    int n_des;
    repeat (2) @(negedge clk2);
    check("reset.outs", all_outs(), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk2);
    check("idle.busy", busy, 0);
    check("idle.samp", dat_samp_en, 0);

    start_frame(1'b0);
    frame_body("clean", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
    start_frame(1'b1);
    frame_body("par_ok", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C);
    start_frame(1'b1);
    frame_body("par_err", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C);
    start_frame(1'b0);
    frame_body("stop_err", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h81);
    start_frame(1'b0);
    frame_body("par_ign", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A);

    start_frame(1'b0);
    frame_body("glitch", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
    n_busy = 0;
    n_des  = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk2);
      n_busy += int'(busy);
      n_des  += int'(deser_en);
    end
    check("glitch.after_busy", n_busy, 0);
    check("glitch.after_deser", n_des, 0);

    // First frame latched par_en=0; toggling it mid-frame must only affect frame two.
    start_frame(1'b0);
    frame_body("b2b1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5);
    frame_body("b2b2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F);

    start_frame(1'b0);
    rx_in = 1'b1;
    repeat (35) @(negedge clk2);
    check("mid.edge", edge_cnt, 3);
    check("mid.busy", busy, 1);
    rst = 1'b0;
    #1;
    check("mid.reset_outs", all_outs(), 0);
    @(negedge clk2);
    rst   = 1'b1;
    rx_in = 1'b1;
    n_busy = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk2);
      n_busy += int'(busy) + int'(dat_samp_en) + int'(data_valid) + int'(deser_en);
    end
    check("post_reset.idle", n_busy, 0);

    start_frame(1'b0);
    frame_body("recover", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
